// File: rtl/addnc_pkg.sv
// Shared definitions for the segmented add/subtract-with-carry pipeline:
// mode encodings and the stage-count helper also used by the Karuta glue.
package addnc_pkg;

    localparam logic ADDNC_MODE_ADD = 1'b0;
    localparam logic ADDNC_MODE_SUB = 1'b1;

    function automatic int addnc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/addnc_seg.sv
// One SEG_W-bit adder stage: registers its sum segment, carry-out and valid
// bit whenever the pipeline advances.
module addnc_seg #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vld_in,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic             vld_out,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_out <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (en) begin
            vld_out     <= vld_in;
            {cout, sum} <= {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/addnc_pipe.sv
// Pipelined add/subtract-with-carry, one SEG_W segment per stage with a
// valid/ready handshake. Define ADDNC_OVERFLOW_EN to add the ret_2 overflow port.
module addnc_pipe import addnc_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_valid,
    output logic             arg_ready,
    input  logic [WIDTH-1:0] arg_0,
    input  logic [WIDTH-1:0] arg_1,
    input  logic             arg_2,
    input  logic             arg_3,
    output logic             ret_valid,
    input  logic             ret_ready,
    output logic             ret_0,
    output logic [WIDTH-1:0] ret_1
`ifdef ADDNC_OVERFLOW_EN
    ,
    output logic             ret_2
`endif
);

    localparam int NSEG = addnc_nseg(WIDTH, SEG_W);

    logic                        adv;
    logic                        sub;
    logic [WIDTH-1:0]            b_cond;
    logic [NSEG:0]               vld_pipe;
    logic [NSEG:0]               cy;
    logic [NSEG-1:0][SEG_W-1:0]  sa, sb, sum;

    // A stalled output freezes every stage, so one signal gates the whole pipe.
    assign adv       = !ret_valid || ret_ready;
    assign arg_ready = adv;

    // Subtract is A + ~B + ~borrow_in, so carry-out reads as not-borrow.
    assign sub         = (arg_3 == ADDNC_MODE_SUB);
    assign b_cond      = sub ? ~arg_1 : arg_1;
    assign cy[0]       = sub ? ~arg_2 : arg_2;
    assign vld_pipe[0] = arg_valid;
    assign sa[0]       = arg_0[SEG_W-1:0];
    assign sb[0]       = b_cond[SEG_W-1:0];

    for (genvar k = 0; k < NSEG; k++) begin : stg
        addnc_seg #(.SEG_W(SEG_W)) u_seg (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .vld_in  (vld_pipe[k]),
            .a       (sa[k]),
            .b       (sb[k]),
            .cin     (cy[k]),
            .vld_out (vld_pipe[k+1]),
            .sum     (sum[k]),
            .cout    (cy[k+1])
        );

        // Operand segments k+1.. not yet consumed ride alongside stage k.
        if (k < NSEG-1) begin : g_skew
            localparam int HW = (NSEG-1-k)*SEG_W;
            logic [HW-1:0] a_hi, b_hi;

            if (k == 0) begin : g_in
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        a_hi <= '0;
                        b_hi <= '0;
                    end else if (adv) begin
                        a_hi <= arg_0[WIDTH-1:SEG_W];
                        b_hi <= b_cond[WIDTH-1:SEG_W];
                    end
                end
            end else begin : g_in
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        a_hi <= '0;
                        b_hi <= '0;
                    end else if (adv) begin
                        a_hi <= stg[k-1].g_skew.a_hi[HW+SEG_W-1:SEG_W];
                        b_hi <= stg[k-1].g_skew.b_hi[HW+SEG_W-1:SEG_W];
                    end
                end
            end

            assign sa[k+1] = a_hi[SEG_W-1:0];
            assign sb[k+1] = b_hi[SEG_W-1:0];
        end

        // Result segments 0..k-1 already resolved travel forward with stage k.
        if (k > 0) begin : g_fwd
            logic [k*SEG_W-1:0] lo;

            if (k == 1) begin : g_lo
                always_ff @(posedge clk) begin
                    if (!rst)     lo <= '0;
                    else if (adv) lo <= sum[0];
                end
            end else begin : g_lo
                always_ff @(posedge clk) begin
                    if (!rst)     lo <= '0;
                    else if (adv) lo <= {sum[k-1], stg[k-1].g_fwd.lo};
                end
            end
        end
    end

    if (NSEG == 1) begin : g_ret1
        assign ret_1 = sum[0];
    end else begin : g_ret
        assign ret_1 = {sum[NSEG-1], stg[NSEG-1].g_fwd.lo};
    end

    assign ret_valid = vld_pipe[NSEG];
    assign ret_0     = cy[NSEG];

`ifdef ADDNC_OVERFLOW_EN
    // Sign bits of the conditioned MSB operands, captured with the last stage;
    // equal signs with a differing result sign is carry-in XOR carry-out at the MSB.
    logic a_msb, b_msb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (adv) begin
            a_msb <= sa[NSEG-1][SEG_W-1];
            b_msb <= sb[NSEG-1][SEG_W-1];
        end
    end

    assign ret_2 = (a_msb == b_msb) && (ret_1[WIDTH-1] != a_msb);
`endif

endmodule

// File: tb/tb_addnc_pipe.sv
// Scoreboard bench for addnc_pipe (WIDTH=16, SEG_W=8): the driver pushes the
// hand-computed result of every accepted operand set, the monitor pops on output.
module tb_addnc_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         arg_valid = 1'b0;
    logic         arg_ready;
    logic [W-1:0] arg_0 = '0;
    logic [W-1:0] arg_1 = '0;
    logic         arg_2 = 1'b0;
    logic         arg_3 = 1'b0;
    logic         ret_valid;
    logic         ret_ready = 1'b1;
    logic         ret_0;
    logic [W-1:0] ret_1;
`ifdef ADDNC_OVERFLOW_EN
    logic         ret_2;
`endif

    addnc_pipe #(.WIDTH(W), .SEG_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg_0     (arg_0),
        .arg_1     (arg_1),
        .arg_2     (arg_2),
        .arg_3     (arg_3),
        .ret_valid (ret_valid),
        .ret_ready (ret_ready),
        .ret_0     (ret_0),
        .ret_1     (ret_1)
`ifdef ADDNC_OVERFLOW_EN
        ,
        .ret_2     (ret_2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (rst && ret_valid && ret_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", {15'd0, ret_0, ret_1}, 32'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ret_1", {16'd0, ret_1}, {16'd0, e.r});
                chk("ret_0", {31'd0, ret_0}, {31'd0, e.c});
`ifdef ADDNC_OVERFLOW_EN
                chk("ret_2", {31'd0, ret_2}, {31'd0, e.o});
`endif
                if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic m, input logic [W-1:0] er, input logic ec,
                        input logic eo, input int lat);
        bit ok;
        exp_t e;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            arg_0 = a; arg_1 = b; arg_2 = ci; arg_3 = m; arg_valid = 1'b1;
            #4;
            if (arg_ready) begin
                ok = 1;
                e.r = er; e.c = ec; e.o = eo; e.acc = cyc; e.lat = lat;
                sb_q.push_back(e);
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            arg_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #4;
        chk("rst_ret_valid", {31'd0, ret_valid}, 32'd0);
        chk("rst_ret_1", {16'd0, ret_1}, 32'd0);
        chk("rst_ret_0", {31'd0, ret_0}, 32'd0);
        chk("rst_arg_ready", {31'd0, arg_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Directed single operations (a, b, cin/borrow, mode, sum, carry, ovf)
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 2);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 2);
        send(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 2);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2);
        send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 2);
        idle(4);

        // Ten back-to-back operations with ret_ready held high
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 2);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 2);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 2);
        send(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 2);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2);
        send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 2);
        send(16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 2);
        send(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0, 2);
        idle(4);

        // Backpressure: fill the pipe, stall five cycles, then release
        @(negedge clk);
        ret_ready = 1'b0;
        send(16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0, -1);
        send(16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            arg_0 = 16'h0100; arg_1 = 16'h0001; arg_2 = 1'b0; arg_3 = 1'b1; arg_valid = 1'b1;
            #4;
            chk("stall_arg_ready", {31'd0, arg_ready}, 32'd0);
            chk("stall_ret_1", {16'd0, ret_1}, 32'h0406);
        end
        @(negedge clk);
        arg_valid = 1'b0;
        ret_ready = 1'b1;
        send(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, -1);
        idle(4);

        // Reset with two operations in flight: both must vanish
        @(negedge clk);
        ret_ready = 1'b0;
        send(16'h5555, 16'h5555, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b1, -1);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, -1);
        @(negedge clk);
        arg_valid = 1'b0;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        #1;
        chk("mid_rst_ret_valid", {31'd0, ret_valid}, 32'd0);
        chk("mid_rst_ret_1", {16'd0, ret_1}, 32'd0);
        chk("mid_rst_ret_0", {31'd0, ret_0}, 32'd0);
`ifdef ADDNC_OVERFLOW_EN
        chk("mid_rst_ret_2", {31'd0, ret_2}, 32'd0);
`endif
        rst = 1'b1;
        ret_ready = 1'b1;
        #3;
        chk("post_rst_arg_ready", {31'd0, arg_ready}, 32'd1);
        idle(4);
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 2);
        idle(1);

        // Drain, bounded
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
        #5;
        chk("drain_pending", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
